// File: rtl/spi_ram_arbiter_if.sv
// Command, response and RAM signals shared by the arbiter and its requesters.
interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic [9:0]           req0_data;
  logic                 req0_valid;
  logic                 req0_ready;
  logic [9:0]           req1_data;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [7:0]           rsp0_data;
  logic                 rsp0_valid;
  logic [7:0]           rsp1_data;
  logic                 rsp1_valid;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;

  // arbiter side
  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid, mem_dout,
    output req0_ready, req1_ready, rsp0_data, rsp0_valid, rsp1_data, rsp1_valid,
           mem_en, mem_we, mem_addr, mem_din
  );

  // requesters plus RAM side
  modport master (
    output req0_data, req0_valid, req1_data, req1_valid, mem_dout,
    input  req0_ready, req1_ready, rsp0_data, rsp0_valid, rsp1_data, rsp1_valid,
           mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Commands: 00 set write ptr, 01 write+inc, 10 set read ptr, 11 read+inc.
module spi_ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_ram_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                    state;
  logic                      rr;      // requester favoured on contention
  logic                      owner;   // requester of the access in flight
  logic [1:0][ADDR_SIZE-1:0] wa, ra;

  logic                 idle, grant0, grant1, acc, win;
  logic [9:0]           cmd;
  logic [1:0]           op;
  logic [ADDR_SIZE-1:0] pay;

  function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] p);
    return (p == ADDR_SIZE'(MEM_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Grant selection; ready is held low while in reset so nothing is accepted then
  always_comb begin
    idle   = rst_n && (state == IDLE);
    grant0 = idle && bus.req0_valid && (!bus.req1_valid || !rr);
    grant1 = idle && bus.req1_valid && (!bus.req0_valid ||  rr);
    acc    = grant0 || grant1;
    win    = grant1;
    cmd    = win ? bus.req1_data : bus.req0_data;
    op     = cmd[9:8];
    pay    = ADDR_SIZE'(cmd[7:0]);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Access sequencer: decode, pointer update, RAM drive and response routing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr             <= 1'b0;
      owner          <= 1'b0;
      wa             <= '0;
      ra             <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_din    <= '0;
      bus.rsp0_data  <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_data  <= '0;
      bus.rsp1_valid <= 1'b0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      unique case (state)
        IDLE: if (acc) begin
          rr <= ~win;
          unique case (op)
            2'b00: wa[win] <= pay;
            2'b10: ra[win] <= pay;
            2'b01: begin
              bus.mem_en   <= 1'b1;
              bus.mem_we   <= 1'b1;
              bus.mem_addr <= wa[win];
              bus.mem_din  <= cmd[7:0];
              wa[win]      <= inc(wa[win]);
              owner        <= win;
              state        <= ACCESS;
            end
            2'b11: begin
              bus.mem_en   <= 1'b1;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= ra[win];
              ra[win]      <= inc(ra[win]);
              owner        <= win;
              state        <= ACCESS;
            end
          endcase
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= bus.mem_we ? IDLE : RESP;
        end
        RESP: begin
          if (owner) begin
            bus.rsp1_data  <= bus.mem_dout;
            bus.rsp1_valid <= 1'b1;
          end else begin
            bus.rsp0_data  <= bus.mem_dout;
            bus.rsp0_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural synchronous RAM.
module tb_spi_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] ram [256];

  spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus();

  spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM model
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout      <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one command for a single cycle; it must be accepted immediately
  task automatic send(input int r, input logic [9:0] d);
    @(negedge clk);
    if (r == 0) begin bus.req0_data = d; bus.req0_valid = 1'b1; end
    else        begin bus.req1_data = d; bus.req1_valid = 1'b1; end
    #1;
    chk($sformatf("ready%0d", r), (r == 0) ? bus.req0_ready : bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    bus.req0_data = '0; bus.req0_valid = 1'b1;
    bus.req1_data = '0; bus.req1_valid = 1'b0;
    bus.mem_dout  = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din}, 0);
    chk("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data}, 0);
    bus.req0_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // set write pointer then write
    send(0, {2'b00, 8'h04});
    chk("wr_en_we", {bus.mem_en, bus.mem_we}, 2'b00);
    send(0, {2'b01, 8'h0F});
    chk("wr_en_we", {bus.mem_en, bus.mem_we}, 2'b11);
    chk("wr_addr", bus.mem_addr, 8'h04);
    chk("wr_din", bus.mem_din, 8'h0F);
    @(posedge clk); #1;
    chk("wr_end", {bus.mem_en, bus.mem_we}, 2'b00);
    send(0, {2'b01, 8'hAA});
    chk("wr_inc_addr", bus.mem_addr, 8'h05);
    @(posedge clk); #1;

    // set read pointer then read back 0x0F
    send(0, {2'b10, 8'h04});
    send(0, {2'b11, 8'h5A});
    chk("rd_en_we", {bus.mem_en, bus.mem_we}, 2'b10);
    chk("rd_addr", bus.mem_addr, 8'h04);
    @(posedge clk); #1;
    chk("rd_early", bus.rsp0_valid, 0);
    @(posedge clk); #1;
    chk("rd_vld0", bus.rsp0_valid, 1);
    chk("rd_data0", bus.rsp0_data, 8'h0F);
    chk("rd_vld1", bus.rsp1_valid, 0);
    @(posedge clk); #1;
    chk("rd_pulse", bus.rsp0_valid, 0);
    chk("rd_hold", bus.rsp0_data, 8'h0F);

    // mid-run reset, then both requesters stream writes
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din}, 0);
    chk("mid_rst_rsp", bus.rsp0_data, 0);
    bus.req0_data = {2'b01, 8'h11}; bus.req0_valid = 1'b1;
    bus.req1_data = {2'b01, 8'h22}; bus.req1_valid = 1'b1;
    #1;
    chk("mid_rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), {bus.req1_ready, bus.req0_ready},
          (k % 4 == 0) ? 2'b01 : (k % 4 == 2) ? 2'b10 : 2'b00);
      @(posedge clk); #1;
      if (k % 2 == 0) begin
        chk($sformatf("rr_addr_%0d", k), bus.mem_addr, k / 4);
        chk($sformatf("rr_din_%0d", k), bus.mem_din, (k % 4 == 0) ? 8'h11 : 8'h22);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // req1 write pointer wrap; req0 pointer untouched
    send(1, {2'b00, 8'hFF});
    send(1, {2'b01, 8'h01});
    chk("wrap_ff", bus.mem_addr, 8'hFF);
    @(posedge clk); #1;
    send(1, {2'b01, 8'h02});
    chk("wrap_00", bus.mem_addr, 8'h00);
    @(posedge clk); #1;
    send(0, {2'b01, 8'h03});
    chk("wa0_kept", bus.mem_addr, 8'h02);
    @(posedge clk); #1;

    // reset during RESP of a req1 read
    send(1, {2'b10, 8'h07});
    send(1, {2'b11, 8'h00});
    chk("rsp_rd_addr", bus.mem_addr, 8'h07);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("resp_rst_vld", bus.rsp1_valid, 0);
    chk("resp_rst_en", bus.mem_en, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("no_rsp_%0d", k), bus.rsp1_valid, 0);
    end
    send(1, {2'b11, 8'h00});
    chk("ra1_reset", bus.mem_addr, 8'h00);
    chk("ra1_we", bus.mem_we, 0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("ra1_vld", bus.rsp1_valid, 1);
    chk("ra1_data", bus.rsp1_data, 8'h02);
    chk("ra1_other", bus.rsp0_valid, 0);
    @(posedge clk); #1;
    chk("ra1_pulse", bus.rsp1_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares one single-port RAM between two command requesters.
  - Port 0 is the SPI slave's rx_data/rx_valid stream.
  - Port 1 is a local host or DMA port.
- Decodes each 10-bit command word (2-bit opcode + 8-bit payload).
- Keeps per-requester write and read address pointers with auto-increment.
- Sequences RAM accesses through a 3-state FSM and routes read data back to the issuing requester's response port, which feeds the SPI slave's tx_data/tx_valid.

Parameters:
- MEM_DEPTH, 256, RAM depth in words; pointers wrap at MEM_DEPTH-1.
- ADDR_SIZE, 8, RAM address width; must satisfy 2^ADDR_SIZE >= MEM_DEPTH.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_data  in  10  command word for requester 0; [9:8] opcode, [7:0] payload.
- req0_valid  in  1  requester 0 command present.
- req0_ready  out  1  requester 0 command accepted this cycle (when valid).
- req1_data  in  10  command word for requester 1.
- req1_valid  in  1  requester 1 command present.
- req1_ready  out  1  requester 1 command accepted.
- rsp0_data  out  8  read data returned to requester 0.
- rsp0_valid  out  1  one-cycle strobe qualifying rsp0_data.
- rsp1_data  out  8  read data returned to requester 1.
- rsp1_valid  out  1  one-cycle strobe qualifying rsp1_data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable (1 = write, 0 = read).
- mem_addr  out  ADDR_SIZE  RAM address.
- mem_din  out  8  RAM write data.
- mem_dout  in  8  RAM read data; synchronous RAM, valid on the edge after a read is presented.

Behaviour:
- Reset, asynchronous (rst_n low):
  - state = IDLE; round-robin pointer = 0.
  - wa0, wa1, ra0, ra1 = 0.
  - All outputs = 0: mem_en, mem_we, mem_addr, mem_din, rsp*_data, rsp*_valid, req*_ready.
  - Any in-flight access is dropped; no response is issued afterwards.
- Opcode decode:
  - 00: wa[i] <= payload. No RAM access; FSM stays in IDLE.
  - 01: write payload to RAM at wa[i]; then wa[i] <= wa[i]+1.
  - 10: ra[i] <= payload. No RAM access; FSM stays in IDLE.
  - 11: read RAM at ra[i]; payload is ignored; then ra[i] <= ra[i]+1.
  - Increment wraps from MEM_DEPTH-1 to 0.
  - A read or write issued before any address command uses address 0.
- Arbitration, IDLE only:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the round-robin pointer's requester.
  - reqN_ready = (state==IDLE) && grantN. ready is combinational from valid.
  - At most one ready is high per cycle.
  - On every acceptance (valid & ready), the pointer moves to the other requester.
  - Outside IDLE, both ready signals are 0.
- FSM:
  - IDLE: accepting opcode 00 or 10 updates the pointer register and stays in IDLE, so one address command per cycle is possible.
  - IDLE: accepting opcode 01 or 11 registers mem_addr, mem_din, mem_we, mem_en=1 and the owner, then goes to ACCESS.
  - ACCESS, 1 cycle: mem_en=1 driven.
    - Write: go to IDLE; mem_en and mem_we return to 0.
    - Read: go to RESP; mem_en returns to 0.
  - RESP, 1 cycle: on the exiting edge, rsp[owner]_data <= mem_dout and rsp[owner]_valid <= 1; go to IDLE.
- Latency, counting acceptance at edge E0:
  - RAM signals are asserted in cycle E0..E1.
  - Read response is valid in cycle E2..E3, high for exactly 1 cycle.
  - The other requester's rsp_valid stays 0.
  - rsp_data holds its value until the next read for that requester.
- Throughput:
  - Address commands: 1 per cycle.
  - Writes: 1 per 2 cycles.
  - Reads: 1 per 3 cycles.
- Simultaneous events: the write/read pointer of the non-accepted requester is never modified.

Test Plan:
- Reset asserted mid-run → all outputs 0, pointers 0. With req0_valid held high, req0_ready=1 in the first IDLE cycle after rst_n rises.
- req0 sends 00_00000100 then 01_00001111 → RAM signals mem_en=1, mem_we=1, mem_addr=0x04, mem_din=0x0F for exactly one cycle after the second acceptance; a subsequent write targets 0x05.
- req0 sends 10_00000100 then 11_xxxxxxxx, RAM model returns 0x0F → mem_en=1, mem_we=0, mem_addr=0x04; rsp0_data=0x0F with rsp0_valid high for one cycle, 2 edges after acceptance; rsp1_valid stays 0.
- Both requesters hold valid with continuous write commands → grants alternate 0,1,0,1, starting with req0 after reset; never two readys in the same cycle.
- req1 sets write address 0xFF, then issues two writes → mem_addr=0xFF, then 0x00 (wrap); wa0 is unchanged.
- Reset pulsed during RESP of a req1 read → rsp1_valid never asserts, state returns to IDLE, and the next read from req1 uses ra1=0.
